reset_sense_sync: RTL and testbench

Consumer end of the generated-reset path. It takes a foreign active-low reset (SRC_RST_N) that may come from any domain and be asserted asynchronously. It produces a CLK-domain reset (OUT_RST_N) that asserts asynchronously and deasserts synchronously, after a stretch. It also reports reset entry and exit events, a sticky "reset seen" flag with an acknowledge handshake, and an optional saturating count of reset events.

---
 rtl/reset_sense_sync_pkg.sv | 21 ++
 rtl/reset_sense_sync_if.sv | 37 +++
 rtl/reset_sync_chain.sv | 40 ++++
 rtl/reset_sense_sync.sv | 133 +++++++++++++
 tb/tb_reset_sense_sync.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/reset_sense_sync_pkg.sv
// Shared types and constants for the reset_sense_sync block and other
// consumers of the generated-reset path.
package reset_sense_pkg;

    // Consumer FSM encoding; 2'd3 is never entered and falls back to IN_RESET.
    typedef enum logic [1:0] {
        IN_RESET = 2'd0,
        HOLDING  = 2'd1,
        RUN      = 2'd2,
        ILLEGAL  = 2'd3
    } rs_state_e;

    // Fewer than two flops gives no metastability settling time.
    localparam int MIN_SYNC_STAGES = 2;

    // Width of a down-counter that must hold values 0..hold, at least 1 bit.
    function automatic int hold_cnt_w(input int hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/reset_sense_sync_if.sv
// Signal bundle between a reset source/observer and reset_sense_sync.
// slave: the reset_sense_sync side; master: the side that drives the foreign
// reset and acknowledge and consumes the status outputs.
interface reset_sense_sync_if #(
    parameter int CNT_W = 8
);
    logic             SRC_RST_N;
    logic             ACK;
    logic             OUT_RST_N;
    logic             IS_RESET;
    logic             ENTER_PULSE;
    logic             EXIT_PULSE;
    logic             SEEN_RESET;
    logic [CNT_W-1:0] RST_COUNT;

    modport slave (
        input  SRC_RST_N,
        input  ACK,
        output OUT_RST_N,
        output IS_RESET,
        output ENTER_PULSE,
        output EXIT_PULSE,
        output SEEN_RESET,
        output RST_COUNT
    );

    modport master (
        output SRC_RST_N,
        output ACK,
        input  OUT_RST_N,
        input  IS_RESET,
        input  ENTER_PULSE,
        input  EXIT_PULSE,
        input  SEEN_RESET,
        input  RST_COUNT
    );
endinterface

// File: rtl/reset_sync_chain.sv
// Asynchronous-assert, synchronous-release synchronizer for a foreign
// active-low reset. Cleared immediately by either the local or the foreign
// reset; the release ripples through SYNC_STAGES flops on CLK.
module reset_sync_chain
    import reset_sense_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic SRC_RST_N,
    output logic sync_hi
);

    // Depths below the legal minimum are raised to it.
    localparam int N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic         clr_n;
    logic [N-1:0] sync_d;
    logic [N-1:0] sync_q;

    assign clr_n = RST_N & SRC_RST_N;

    // Shift a constant one in from stage 0 toward the output stage.
    always_comb begin
        sync_d = {sync_q[N-2:0], 1'b1};
    end

    // Chain flops, cleared asynchronously whenever either reset is low.
    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_hi = sync_q[N-1];

endmodule

// File: rtl/reset_sense_sync.sv
// Consumer end of the generated-reset path. Produces a CLK-domain reset
// that asserts asynchronously with SRC_RST_N and releases synchronously
// after SYNC_STAGES + HOLD + 1 edges, plus entry/exit pulses, a sticky
// seen flag cleared by ACK, and an optional saturating entry counter
// (enabled by defining RESET_SENSE_COUNT_EN; otherwise RST_COUNT is 0).
module reset_sense_sync
    import reset_sense_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 4,
    parameter int CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    reset_sense_sync_if.slave rs
);

    localparam int                HOLD_W    = hold_cnt_w(HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD > 0) ? HOLD - 1 : 0);

    logic              sync_hi;
    rs_state_e         state_d;
    rs_state_e         state_q;
    logic [HOLD_W-1:0] cnt_d;
    logic [HOLD_W-1:0] cnt_q;
    logic              enter_d;
    logic              enter_q;
    logic              exit_d;
    logic              exit_q;
    logic              seen_d;
    logic              seen_q;

    reset_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SRC_RST_N (rs.SRC_RST_N),
        .sync_hi   (sync_hi)
    );

    // Next state, hold countdown and event/flag next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!sync_hi) begin
            // Any drop of the synchronized reset restarts from IN_RESET;
            // a later release reloads the hold from scratch.
            state_d = IN_RESET;
        end else begin
            case (state_q)
                IN_RESET: begin
                    if (HOLD == 0) begin
                        state_d = RUN;
                    end else begin
                        state_d = HOLDING;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                HOLDING: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - HOLD_W'(1);
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = IN_RESET;
                end
            endcase
        end

        // Entry is only counted when leaving a running state.
        enter_d = (state_q == RUN) && (state_d == IN_RESET);
        exit_d  = (state_d == RUN) && (state_q != RUN);
        // Entry wins over a simultaneous acknowledge.
        seen_d  = enter_d | (seen_q & ~rs.ACK);
    end

    // FSM and status flops, owned by the local reset only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IN_RESET;
            cnt_q   <= '0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            seen_q  <= seen_d;
        end
    end

    // Assertion follows sync_hi combinationally; release needs the RUN state.
    assign rs.OUT_RST_N   = (state_q == RUN) & sync_hi;
    assign rs.IS_RESET    = ~rs.OUT_RST_N;
    assign rs.ENTER_PULSE = enter_q;
    assign rs.EXIT_PULSE  = exit_q;
    assign rs.SEEN_RESET  = seen_q;

`ifdef RESET_SENSE_COUNT_EN
    logic [CNT_W-1:0] rcnt_d;
    logic [CNT_W-1:0] rcnt_q;

    // Saturating increment on every reset entry.
    always_comb begin
        rcnt_d = rcnt_q;
        if (enter_d && (rcnt_q != '1)) begin
            rcnt_d = rcnt_q + CNT_W'(1);
        end
    end

    // Entry counter register, cleared by the local reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end

    assign rs.RST_COUNT = rcnt_q;
`else
    assign rs.RST_COUNT = '0;
`endif

endmodule

// File: tb/tb_reset_sense_sync.sv
// Directed bench for reset_sense_sync: default instance (SYNC_STAGES=2,
// HOLD=4) plus a SYNC_STAGES=3, HOLD=0 instance sharing CLK and RST_N.
module tb_reset_sense_sync;

`ifdef RESET_SENSE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   exp_cnt = 0;

    reset_sense_sync_if #(.CNT_W(8)) if_a ();
    reset_sense_sync_if #(.CNT_W(8)) if_b ();

    reset_sense_sync #(.SYNC_STAGES(2), .HOLD(4), .CNT_W(8)) u_dut_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .rs    (if_a)
    );

    reset_sense_sync #(.SYNC_STAGES(3), .HOLD(0), .CNT_W(8)) u_dut_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .rs    (if_b)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int cnt_exp(input int n);
        return CNT_EN ? ((n > 255) ? 255 : n) : 0;
    endfunction

    initial begin
        if_a.SRC_RST_N = 1'b1;
        if_a.ACK       = 1'b0;
        if_b.SRC_RST_N = 1'b1;
        if_b.ACK       = 1'b0;
        RST_N          = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        // reset values before any clock edge
        check("rst_out_a",   if_a.OUT_RST_N,   0);
        check("rst_is_a",    if_a.IS_RESET,    1);
        check("rst_enter_a", if_a.ENTER_PULSE, 0);
        check("rst_exit_a",  if_a.EXIT_PULSE,  0);
        check("rst_seen_a",  if_a.SEEN_RESET,  0);
        check("rst_cnt_a",   if_a.RST_COUNT,   0);
        check("rst_out_b",   if_b.OUT_RST_N,   0);
        tick();
        tick();
        check("rst_hold_out_a", if_a.OUT_RST_N, 0);

        // test 1 / test 6 latency: release local reset with SRC high
        RST_N = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t1_out_a",   if_a.OUT_RST_N,   k >= 7);
            check("t1_exit_a",  if_a.EXIT_PULSE,  k == 7);
            check("t1_enter_a", if_a.ENTER_PULSE, 0);
            check("t6_out_b",   if_b.OUT_RST_N,   k >= 4);
            check("t6_exit_b",  if_b.EXIT_PULSE,  k == 4);
        end
        check("t1_seen_a", if_a.SEEN_RESET, 0);
        check("t1_cnt_a",  if_a.RST_COUNT,  0);

        // test 2: entry from RUN, 3 cycles low
        if_a.SRC_RST_N = 1'b0;
        #1;
        check("t2_out_comb", if_a.OUT_RST_N, 0);
        check("t2_is_comb",  if_a.IS_RESET,  1);
        tick();
        exp_cnt++;
        check("t2_enter", if_a.ENTER_PULSE, 1);
        check("t2_seen",  if_a.SEEN_RESET,  1);
        check("t2_cnt",   if_a.RST_COUNT,   cnt_exp(exp_cnt));
        tick();
        check("t2_enter_1cyc", if_a.ENTER_PULSE, 0);
        tick();
        if_a.SRC_RST_N = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t2_out",   if_a.OUT_RST_N,   k >= 7);
            check("t2_exit",  if_a.EXIT_PULSE,  k == 7);
            check("t2_enter", if_a.ENTER_PULSE, 0);
        end

        // test 3: glitch during HOLDING restarts the full release
        if_a.SRC_RST_N = 1'b0;
        tick();
        exp_cnt++;
        if_a.SRC_RST_N = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t3_out_pre", if_a.OUT_RST_N, 0);
        end
        if_a.SRC_RST_N = 1'b0;
        tick();
        check("t3_no_enter", if_a.ENTER_PULSE, 0);
        check("t3_out_low",  if_a.OUT_RST_N,   0);
        if_a.SRC_RST_N = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t3_out",   if_a.OUT_RST_N,   k >= 7);
            check("t3_enter", if_a.ENTER_PULSE, 0);
        end
        check("t3_cnt", if_a.RST_COUNT, cnt_exp(exp_cnt));

        // test 4: ACK alone clears; ACK with entry loses to set
        if_a.ACK = 1'b1;
        tick();
        if_a.ACK = 1'b0;
        check("t4_ack_clear", if_a.SEEN_RESET, 0);
        if_a.ACK       = 1'b1;
        if_a.SRC_RST_N = 1'b0;
        tick();
        exp_cnt++;
        check("t4_set_wins", if_a.SEEN_RESET,  1);
        check("t4_enter",    if_a.ENTER_PULSE, 1);
        if_a.ACK       = 1'b0;
        if_a.SRC_RST_N = 1'b1;
        tick();
        check("t4_seen_hold", if_a.SEEN_RESET, 1);
        if_a.ACK = 1'b1;
        tick();
        if_a.ACK = 1'b0;
        check("t4_ack_later", if_a.SEEN_RESET, 0);
        for (int k = 3; k <= 7; k++) tick();
        check("t4_out", if_a.OUT_RST_N, 1);

        // test 5: 300 entries saturate the counter
        for (int i = 0; i < 300; i++) begin
            if_a.SRC_RST_N = 1'b0;
            tick();
            exp_cnt++;
            if_a.SRC_RST_N = 1'b1;
            repeat (7) tick();
        end
        check("t5_cnt_sat", if_a.RST_COUNT, cnt_exp(exp_cnt));
        check("t5_out",     if_a.OUT_RST_N, 1);

        // test 6: local reset mid-HOLDING
        if_a.SRC_RST_N = 1'b0;
        tick();
        exp_cnt++;
        if_a.SRC_RST_N = 1'b1;
        repeat (4) tick();
        check("t6_out_hold", if_a.OUT_RST_N,  0);
        check("t6_seen_pre", if_a.SEEN_RESET, 1);
        RST_N = 1'b0;
        #1;
        check("t6_out_a",   if_a.OUT_RST_N,   0);
        check("t6_is_a",    if_a.IS_RESET,    1);
        check("t6_enter_a", if_a.ENTER_PULSE, 0);
        check("t6_exit_a",  if_a.EXIT_PULSE,  0);
        check("t6_seen_a",  if_a.SEEN_RESET,  0);
        check("t6_cnt_a",   if_a.RST_COUNT,   0);
        check("t6_out_b_rst", if_b.OUT_RST_N, 0);
        check("t6_is_b_rst",  if_b.IS_RESET,  1);
        exp_cnt = 0;
        tick();
        RST_N = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t6_rel_out_a",   if_a.OUT_RST_N,   k >= 7);
            check("t6_rel_exit_a",  if_a.EXIT_PULSE,  k == 7);
            check("t6_rel_enter_a", if_a.ENTER_PULSE, 0);
            check("t6_rel_out_b",   if_b.OUT_RST_N,   k >= 4);
        end
        check("t6_rel_cnt_a", if_a.RST_COUNT, cnt_exp(exp_cnt));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
